// File: rtl/warp_scheduler.sv
// Warp launch scheduler: queues launch requests, dispatches them round-robin to idle
// simd cores, tracks each core's run state and retires one completed warp per cycle.
module warp_scheduler #(
  parameter int NUM_CORES   = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int WARP_ID_W   = 4,
  parameter int PC_W        = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               launch_valid,
  output logic                               launch_ready,
  input  logic [WARP_ID_W-1:0]               launch_warp_id,
  input  logic [PC_W-1:0]                    launch_start_pc,
  input  logic [NUM_CORES-1:0]               core_finished,
  input  logic [NUM_CORES*WARP_ID_W-1:0]     core_finished_warp_id,
  output logic [NUM_CORES-1:0]               dispatch_valid,
  output logic [NUM_CORES*WARP_ID_W-1:0]     dispatch_warp_id,
  output logic [NUM_CORES*PC_W-1:0]          dispatch_start_pc,
  output logic [NUM_CORES-1:0]               core_busy,
  output logic                               retire_valid,
  output logic [WARP_ID_W-1:0]               retire_warp_id,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic                               all_idle,
  output logic                               err_mismatch
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH+1);
  localparam int RR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DISPATCH = 3'd1;
  localparam logic [2:0] ST_WAIT_GO  = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [WARP_ID_W-1:0]           fifo_id_q [QUEUE_DEPTH];
  logic [PC_W-1:0]                fifo_pc_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic [RR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [2:0]                     state_q [NUM_CORES];
  logic [2:0]                     state_d [NUM_CORES];
  logic [NUM_CORES-1:0]           dispatch_valid_q, dispatch_valid_d;
  logic [NUM_CORES*WARP_ID_W-1:0] dispatch_warp_id_q, dispatch_warp_id_d;
  logic [NUM_CORES*PC_W-1:0]      dispatch_start_pc_q, dispatch_start_pc_d;
  logic                           retire_valid_q, retire_valid_d;
  logic [WARP_ID_W-1:0]           retire_warp_id_q, retire_warp_id_d;
  logic                           err_mismatch_q, err_mismatch_d;

  logic                           push, pop;
  logic                           grant_valid;
  logic [RR_W-1:0]                grant_idx;
  logic [RR_W-1:0]                cand;
  logic                           ret_valid;
  logic [RR_W-1:0]                ret_idx;

  assign launch_ready = (count_q != CNT_W'(QUEUE_DEPTH));
  assign push         = launch_valid && launch_ready;
  assign pop          = grant_valid;

  // Dispatch grant: first idle core scanning cyclically from the round-robin pointer.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = RR_W'((int'(rr_ptr_q) + k) % NUM_CORES);
      if (!grant_valid && (count_q != '0) && (state_q[cand] == ST_IDLE)) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    ret_valid = 1'b0;
    ret_idx   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!ret_valid && (state_q[i] == ST_DONE)) begin
        ret_valid = 1'b1;
        ret_idx   = RR_W'(i);
      end
    end
  end

  always_comb begin
    wr_ptr_d            = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d            = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d             = count_q;
    rr_ptr_d            = rr_ptr_q;
    dispatch_valid_d    = '0;
    dispatch_warp_id_d  = dispatch_warp_id_q;
    dispatch_start_pc_d = dispatch_start_pc_q;
    retire_valid_d      = ret_valid;
    retire_warp_id_d    = '0;
    err_mismatch_d      = err_mismatch_q;

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end

    if (grant_valid) begin
      rr_ptr_d = (int'(grant_idx) == NUM_CORES-1) ? '0 : grant_idx + 1'b1;
    end

    for (int i = 0; i < NUM_CORES; i++) begin
      state_d[i] = state_q[i];
      if (grant_valid && (grant_idx == RR_W'(i))) begin
        dispatch_valid_d[i]                         = 1'b1;
        dispatch_warp_id_d[i*WARP_ID_W +: WARP_ID_W] = fifo_id_q[rd_ptr_q];
        dispatch_start_pc_d[i*PC_W +: PC_W]          = fifo_pc_q[rd_ptr_q];
      end
      if (ret_valid && (ret_idx == RR_W'(i))) begin
        retire_warp_id_d = dispatch_warp_id_q[i*WARP_ID_W +: WARP_ID_W];
      end
      // A core idles with finished asserted, so completion only counts after it drops.
      case (state_q[i])
        ST_IDLE: begin
          if (grant_valid && (grant_idx == RR_W'(i))) state_d[i] = ST_DISPATCH;
        end
        ST_DISPATCH: state_d[i] = ST_WAIT_GO;
        ST_WAIT_GO: begin
          if (!core_finished[i]) state_d[i] = ST_RUN;
        end
        ST_RUN: begin
          if (core_finished[i]) begin
            if (core_finished_warp_id[i*WARP_ID_W +: WARP_ID_W] ==
                dispatch_warp_id_q[i*WARP_ID_W +: WARP_ID_W]) begin
              state_d[i] = ST_DONE;
            end else begin
              err_mismatch_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ret_valid && (ret_idx == RR_W'(i))) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q            <= '0;
      rd_ptr_q            <= '0;
      count_q             <= '0;
      rr_ptr_q            <= '0;
      dispatch_valid_q    <= '0;
      dispatch_warp_id_q  <= '0;
      dispatch_start_pc_q <= '0;
      retire_valid_q      <= 1'b0;
      retire_warp_id_q    <= '0;
      err_mismatch_q      <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) state_q[i] <= ST_IDLE;
    end else begin
      wr_ptr_q            <= wr_ptr_d;
      rd_ptr_q            <= rd_ptr_d;
      count_q             <= count_d;
      rr_ptr_q            <= rr_ptr_d;
      dispatch_valid_q    <= dispatch_valid_d;
      dispatch_warp_id_q  <= dispatch_warp_id_d;
      dispatch_start_pc_q <= dispatch_start_pc_d;
      retire_valid_q      <= retire_valid_d;
      retire_warp_id_q    <= retire_warp_id_d;
      err_mismatch_q      <= err_mismatch_d;
      for (int i = 0; i < NUM_CORES; i++) state_q[i] <= state_d[i];
    end
  end

  // Queue storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_id_q[wr_ptr_q] <= launch_warp_id;
      fifo_pc_q[wr_ptr_q] <= launch_start_pc;
    end
  end

  always_comb begin
    core_busy = '0;
    for (int i = 0; i < NUM_CORES; i++) core_busy[i] = (state_q[i] != ST_IDLE);
  end

  assign all_idle          = (count_q == '0) && (core_busy == '0);
  assign queue_count       = count_q;
  assign dispatch_valid    = dispatch_valid_q;
  assign dispatch_warp_id  = dispatch_warp_id_q;
  assign dispatch_start_pc = dispatch_start_pc_q;
  assign retire_valid      = retire_valid_q;
  assign retire_warp_id    = retire_warp_id_q;
  assign err_mismatch      = err_mismatch_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// Bench for warp_scheduler: a table of single-warp vectors, hand-written corner
// sequences, and a random run checked against a queue/flag reference model.
module tb_warp_scheduler;

  localparam int NC = 4;
  localparam int QD = 8;
  localparam int W  = 4;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          launch_valid = 1'b0;
  logic          launch_ready;
  logic [W-1:0]  launch_warp_id = '0;
  logic [PW-1:0] launch_start_pc = '0;
  logic [NC-1:0] core_finished = '1;
  logic [NC*W-1:0] core_finished_warp_id = '1;
  logic [NC-1:0] dispatch_valid;
  logic [NC*W-1:0] dispatch_warp_id;
  logic [NC*PW-1:0] dispatch_start_pc;
  logic [NC-1:0] core_busy;
  logic          retire_valid;
  logic [W-1:0]  retire_warp_id;
  logic [3:0]    queue_count;
  logic          all_idle;
  logic          err_mismatch;

  int n_vec  = 0;
  int n_fail = 0;

  warp_scheduler #(.NUM_CORES(NC), .QUEUE_DEPTH(QD), .WARP_ID_W(W), .PC_W(PW)) dut (
    .clk(clk), .rst(rst),
    .launch_valid(launch_valid), .launch_ready(launch_ready),
    .launch_warp_id(launch_warp_id), .launch_start_pc(launch_start_pc),
    .core_finished(core_finished), .core_finished_warp_id(core_finished_warp_id),
    .dispatch_valid(dispatch_valid), .dispatch_warp_id(dispatch_warp_id),
    .dispatch_start_pc(dispatch_start_pc), .core_busy(core_busy),
    .retire_valid(retire_valid), .retire_warp_id(retire_warp_id),
    .queue_count(queue_count), .all_idle(all_idle), .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          lv;
    logic [W-1:0]  lid;
    logic [PW-1:0] lpc;
    logic [NC-1:0] fin;
    logic [NC*W-1:0] fid;
    logic [NC-1:0] exp_dv;
    logic          exp_rv;
    logic [W-1:0]  exp_rid;
    int            exp_qc;
    logic [NC-1:0] exp_busy;
    logic          exp_idle;
  } vec_t;

  typedef struct {
    logic [W-1:0]  id;
    logic [PW-1:0] pc;
  } entry_t;

  // Reference model: pending launches as a queue, each core as a few flags.
  entry_t        m_q[$];
  bit            m_active[NC], m_fresh[NC], m_armed[NC], m_complete[NC];
  logic [W-1:0]  m_id[NC];
  logic [PW-1:0] m_pc[NC];
  int            m_rr;
  bit            m_err, m_retv;
  logic [W-1:0]  m_retid;
  logic [NC-1:0] m_dv;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic lv, input logic [W-1:0] lid, input logic [PW-1:0] lpc,
                                input logic [NC-1:0] fin, input logic [NC*W-1:0] fid);
    launch_valid          = lv;
    launch_warp_id        = lid;
    launch_start_pc       = lpc;
    core_finished         = fin;
    core_finished_warp_id = fid;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, '0, '0, '1, '1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    m_q.delete();
    for (int i = 0; i < NC; i++) begin
      m_active[i] = 0; m_fresh[i] = 0; m_armed[i] = 0; m_complete[i] = 0;
      m_id[i] = '0; m_pc[i] = '0;
    end
    m_rr = 0; m_err = 0; m_retv = 0; m_retid = '0; m_dv = '0;
  endtask

  task automatic model_step();
    bit pushed;
    int win, g, c;
    entry_t e;
    pushed = launch_valid && (m_q.size() != QD);
    win = -1;
    for (int i = 0; i < NC; i++) if (m_complete[i] && win < 0) win = i;
    g = -1;
    if (m_q.size() > 0)
      for (int k = 0; k < NC; k++) begin
        c = (m_rr + k) % NC;
        if (g < 0 && !m_active[c]) g = c;
      end
    m_retv  = (win >= 0);
    m_retid = (win >= 0) ? m_id[win] : '0;
    m_dv    = '0;
    for (int i = 0; i < NC; i++) begin
      if (!m_active[i]) continue;
      if (m_complete[i]) begin
        if (i == win) begin m_active[i] = 0; m_complete[i] = 0; end
      end else if (m_fresh[i]) begin
        m_fresh[i] = 0;
      end else if (!m_armed[i]) begin
        if (!core_finished[i]) m_armed[i] = 1;
      end else if (core_finished[i]) begin
        if (core_finished_warp_id[i*W +: W] == m_id[i]) m_complete[i] = 1;
        else m_err = 1;
      end
    end
    if (g >= 0) begin
      e = m_q.pop_front();
      m_active[g] = 1; m_fresh[g] = 1; m_armed[g] = 0; m_complete[g] = 0;
      m_id[g] = e.id; m_pc[g] = e.pc; m_dv[g] = 1'b1;
      m_rr = (g + 1) % NC;
    end
    if (pushed) begin
      e.id = launch_warp_id;
      e.pc = launch_start_pc;
      m_q.push_back(e);
    end
  endtask

  task automatic check_model();
    logic [NC-1:0] busy;
    busy = '0;
    for (int i = 0; i < NC; i++) busy[i] = m_active[i];
    check_output("rnd_ready", 64'(launch_ready), 64'(m_q.size() != QD));
    check_output("rnd_qcount", 64'(queue_count), 64'(m_q.size()));
    check_output("rnd_busy", 64'(core_busy), 64'(busy));
    check_output("rnd_all_idle", 64'(all_idle), 64'((m_q.size() == 0) && (busy == '0)));
    check_output("rnd_dvalid", 64'(dispatch_valid), 64'(m_dv));
    check_output("rnd_rvalid", 64'(retire_valid), 64'(m_retv));
    if (m_retv) check_output("rnd_rid", 64'(retire_warp_id), 64'(m_retid));
    check_output("rnd_err", 64'(err_mismatch), 64'(m_err));
    for (int i = 0; i < NC; i++) begin
      check_output("rnd_did", 64'(dispatch_warp_id[i*W +: W]), 64'(m_id[i]));
      check_output("rnd_dpc", 64'(dispatch_start_pc[i*PW +: PW]), 64'(m_pc[i]));
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [NC-1:0] fin;
    logic [NC*W-1:0] fid;

    // Reset values
    do_reset();
    check_output("rst_ready", 64'(launch_ready), 64'd1);
    check_output("rst_qcount", 64'(queue_count), 64'd0);
    check_output("rst_all_idle", 64'(all_idle), 64'd1);
    check_output("rst_busy", 64'(core_busy), 64'd0);
    check_output("rst_dvalid", 64'(dispatch_valid), 64'd0);
    check_output("rst_rvalid", 64'(retire_valid), 64'd0);
    check_output("rst_err", 64'(err_mismatch), 64'd0);
    check_output("rst_did", 64'(dispatch_warp_id), 64'd0);

    // Single warp launch through retire
    vecs[0] = '{1'b1, 4'd3, 32'h100, 4'hF, 16'hFFFF, 4'b0000, 1'b0, 4'd0, 1, 4'b0000, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 32'h0,   4'hF, 16'hFFFF, 4'b0001, 1'b0, 4'd0, 0, 4'b0001, 1'b0};
    vecs[2] = '{1'b0, 4'd0, 32'h0,   4'hF, 16'hFFFF, 4'b0000, 1'b0, 4'd0, 0, 4'b0001, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 32'h0,   4'hE, 16'hFFFF, 4'b0000, 1'b0, 4'd0, 0, 4'b0001, 1'b0};
    vecs[4] = '{1'b0, 4'd0, 32'h0,   4'hF, 16'hFFF3, 4'b0000, 1'b0, 4'd0, 0, 4'b0001, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 32'h0,   4'hF, 16'hFFF3, 4'b0000, 1'b1, 4'd3, 0, 4'b0000, 1'b1};
    vecs[6] = '{1'b0, 4'd0, 32'h0,   4'hF, 16'hFFF3, 4'b0000, 1'b0, 4'd0, 0, 4'b0000, 1'b1};
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(vecs[v].lv, vecs[v].lid, vecs[v].lpc, vecs[v].fin, vecs[v].fid);
      step();
      check_output("t1_dvalid", 64'(dispatch_valid), 64'(vecs[v].exp_dv));
      check_output("t1_rvalid", 64'(retire_valid), 64'(vecs[v].exp_rv));
      if (vecs[v].exp_rv) check_output("t1_rid", 64'(retire_warp_id), 64'(vecs[v].exp_rid));
      check_output("t1_qcount", 64'(queue_count), 64'(vecs[v].exp_qc));
      check_output("t1_busy", 64'(core_busy), 64'(vecs[v].exp_busy));
      check_output("t1_all_idle", 64'(all_idle), 64'(vecs[v].exp_idle));
      if (vecs[v].exp_dv[0]) begin
        check_output("t1_dpc", 64'(dispatch_start_pc[PW-1:0]), 64'h100);
        check_output("t1_did", 64'(dispatch_warp_id[W-1:0]), 64'd3);
      end
    end

    // Fill the queue with all cores stuck waiting for finished to drop
    do_reset();
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(1'b1, W'(k), PW'(k * 4), 4'hF, 16'hFFFF);
      step();
    end
    check_output("t2_qcount_full", 64'(queue_count), 64'd8);
    check_output("t2_ready_full", 64'(launch_ready), 64'd0);
    apply_stimulus(1'b1, 4'd12, 32'h30, 4'hF, 16'hFFFF);
    step();
    check_output("t2_qcount_9th", 64'(queue_count), 64'd8);
    check_output("t2_ready_9th", 64'(launch_ready), 64'd0);
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'hE, 16'hFFFF);
    step();
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'hF, 16'hFFF0);
    step();
    step();
    check_output("t2_rvalid", 64'(retire_valid), 64'd1);
    check_output("t2_rid", 64'(retire_warp_id), 64'd0);
    check_output("t2_ready_still_full", 64'(launch_ready), 64'd0);
    step();
    check_output("t2_dvalid", 64'(dispatch_valid), 64'b0001);
    check_output("t2_did", 64'(dispatch_warp_id[W-1:0]), 64'd4);
    check_output("t2_qcount_pop", 64'(queue_count), 64'd7);
    check_output("t2_ready_pop", 64'(launch_ready), 64'd1);

    // Round-robin fill, then two simultaneous completions on cores 1 and 2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1'b1, W'(k), PW'(32'h1000 + k), 4'hF, 16'hFFFF);
      step();
      if (k >= 1 && k <= 4) check_output("t3_rr_dvalid", 64'(dispatch_valid), 64'(4'b0001 << (k - 1)));
    end
    check_output("t3_dvalid_none", 64'(dispatch_valid), 64'd0);
    check_output("t3_qcount", 64'(queue_count), 64'd2);
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'h0, 16'hFFFF);
    step();
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'b0001, 16'hFFF0);
    step();
    step();
    check_output("t3_rvalid", 64'(retire_valid), 64'd1);
    check_output("t3_rid", 64'(retire_warp_id), 64'd0);
    step();
    check_output("t3_resume_dvalid", 64'(dispatch_valid), 64'b0001);
    check_output("t3_resume_did", 64'(dispatch_warp_id[W-1:0]), 64'd4);
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'b0110, 16'hF21F);
    step();
    step();
    check_output("t4_first_rvalid", 64'(retire_valid), 64'd1);
    check_output("t4_first_rid", 64'(retire_warp_id), 64'd1);
    check_output("t4_no_regrant", 64'(dispatch_valid), 64'd0);
    step();
    check_output("t4_second_rvalid", 64'(retire_valid), 64'd1);
    check_output("t4_second_rid", 64'(retire_warp_id), 64'd2);
    check_output("t4_regrant_dvalid", 64'(dispatch_valid), 64'b0010);
    check_output("t4_regrant_did", 64'(dispatch_warp_id[2*W-1:W]), 64'd5);
    check_output("t4_qcount", 64'(queue_count), 64'd0);

    // Mismatched finish id sets the sticky error and keeps the core running
    do_reset();
    apply_stimulus(1'b1, 4'd2, 32'h200, 4'hF, 16'hFFFF);
    step();
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'hF, 16'hFFFF);
    step();
    step();
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'hE, 16'hFFFF);
    step();
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'hF, 16'hFFF5);
    step();
    check_output("t5_err", 64'(err_mismatch), 64'd1);
    check_output("t5_busy", 64'(core_busy), 64'b0001);
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'hE, 16'hFFFF);
    step();
    check_output("t5_err_sticky", 64'(err_mismatch), 64'd1);
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'hF, 16'hFFF2);
    step();
    step();
    check_output("t5_rvalid", 64'(retire_valid), 64'd1);
    check_output("t5_rid", 64'(retire_warp_id), 64'd2);
    check_output("t5_err_kept", 64'(err_mismatch), 64'd1);

    // Asynchronous reset with work queued and in flight
    do_reset();
    for (int k = 0; k < 7; k++) begin
      apply_stimulus(1'b1, W'(k), PW'(k), 4'hF, 16'hFFFF);
      step();
    end
    apply_stimulus(1'b0, 4'd0, 32'h0, 4'hF, 16'hFFFF);
    check_output("t6_qcount_before", 64'(queue_count), 64'd3);
    rst = 1'b0;
    #1;
    check_output("t6_qcount", 64'(queue_count), 64'd0);
    check_output("t6_busy", 64'(core_busy), 64'd0);
    check_output("t6_ready", 64'(launch_ready), 64'd1);
    check_output("t6_rvalid", 64'(retire_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check_output("t6_rvalid_after", 64'(retire_valid), 64'd0);
    check_output("t6_all_idle", 64'(all_idle), 64'd1);

    // Random traffic against the reference model
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      fin = '0;
      fid = '0;
      for (int i = 0; i < NC; i++) begin
        fin[i] = ($urandom % 4) != 0;
        fid[i*W +: W] = (($urandom % 10) == 0) ? W'($urandom_range(0, 14)) : m_id[i];
      end
      apply_stimulus(1'($urandom % 2), W'($urandom_range(0, 14)), PW'($urandom), fin, fid);
      @(posedge clk);
      model_step();
      #1;
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
